// File: rtl/tcm_boot_loader.sv
// Boot loader: optionally zero-fills the TCM, copies the boot image from ROM,
// then releases the core from reset and watches how long it runs.
module tcm_boot_loader #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int LOAD_BYTES = 131072,
  parameter int CLEAR_EN   = 1,
  parameter int MAX_CYCLES = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  output logic                o_src_rd,
  output logic [ADDR_W-1:0]   o_src_addr,
  input  logic [DATA_W-1:0]   i_src_rdata,
  output logic                o_tcm_valid,
  input  logic                i_tcm_ready,
  output logic [ADDR_W-1:0]   o_tcm_addr,
  output logic [DATA_W-1:0]   o_tcm_wdata,
  output logic [DATA_W/8-1:0] o_tcm_wstrb,
  output logic                o_core_rstn,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_timeout,
  output logic [31:0]         o_cycle_cnt
);

  localparam int BPB    = DATA_W / 8;
  localparam int NBEATS = (LOAD_BYTES + BPB - 1) / BPB;
  localparam int REM    = LOAD_BYTES % BPB;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_CAPT  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_RUN   = 3'd5;
  localparam logic [2:0] S_TMO   = 3'd6;

  // Byte enables of the final beat: only the bytes that belong to the image.
  function automatic logic [BPB-1:0] tail_strb(input int rem);
    logic [BPB-1:0] s;
    s = {BPB{1'b0}};
    for (int i = 0; i < BPB; i++) begin
      if ((rem == 0) || (i < rem)) begin
        s[i] = 1'b1;
      end else begin
        s[i] = 1'b0;
      end
    end
    return s;
  endfunction

  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] k);
    return k * ADDR_W'(BPB);
  endfunction

  localparam logic [ADDR_W-1:0] LAST_K      = ADDR_W'(NBEATS - 1);
  localparam logic [BPB-1:0]    FULL_STRB   = {BPB{1'b1}};
  localparam logic [BPB-1:0]    LAST_STRB   = tail_strb(REM);
  localparam logic [31:0]       WD_LAST     = 32'(MAX_CYCLES) - 32'd1;
  localparam logic [2:0]        START_STATE = (CLEAR_EN != 0) ? S_CLEAR : S_READ;

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [ADDR_W-1:0] k_r;
  logic [ADDR_W-1:0] k_nxt_s;
  logic [DATA_W-1:0] data_r;
  logic [DATA_W-1:0] data_nxt_s;
  logic [31:0]       cnt_nxt_s;
  logic              last_s;

  logic              src_rd_nxt_s;
  logic [ADDR_W-1:0] src_addr_nxt_s;
  logic              valid_nxt_s;
  logic [ADDR_W-1:0] tcm_addr_nxt_s;
  logic [DATA_W-1:0] wdata_nxt_s;
  logic [BPB-1:0]    wstrb_nxt_s;
  logic              busy_nxt_s;
  logic              run_nxt_s;
  logic              tmo_nxt_s;

  assign last_s = (k_r == LAST_K);

  // Next state, beat index, captured data and run counter.
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    data_nxt_s  = data_r;
    cnt_nxt_s   = o_cycle_cnt;
    case (state_r)
      S_IDLE: begin
        if (i_start) begin
          k_nxt_s     = {ADDR_W{1'b0}};
          state_nxt_s = START_STATE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (i_tcm_ready && last_s) begin
          k_nxt_s     = {ADDR_W{1'b0}};
          state_nxt_s = S_READ;
        end else if (i_tcm_ready) begin
          k_nxt_s     = k_r + ADDR_W'(1);
          state_nxt_s = S_CLEAR;
        end else begin
          state_nxt_s = S_CLEAR;
        end
      end
      S_READ: begin
        state_nxt_s = S_CAPT;
      end
      S_CAPT: begin
        data_nxt_s  = i_src_rdata;
        state_nxt_s = S_WRITE;
      end
      S_WRITE: begin
        if (i_tcm_ready && last_s) begin
          cnt_nxt_s   = 32'd0;
          state_nxt_s = S_RUN;
        end else if (i_tcm_ready) begin
          k_nxt_s     = k_r + ADDR_W'(1);
          state_nxt_s = S_READ;
        end else begin
          state_nxt_s = S_WRITE;
        end
      end
      S_RUN: begin
        if (i_start) begin
          cnt_nxt_s   = 32'd0;
          k_nxt_s     = {ADDR_W{1'b0}};
          state_nxt_s = START_STATE;
        end else begin
          if (o_cycle_cnt != 32'hFFFF_FFFF) begin
            cnt_nxt_s = o_cycle_cnt + 32'd1;
          end else begin
            cnt_nxt_s = o_cycle_cnt;
          end
          // The final counted cycle lands the frozen count exactly on MAX_CYCLES.
          if ((MAX_CYCLES != 0) && (o_cycle_cnt == WD_LAST)) begin
            state_nxt_s = S_TMO;
          end else begin
            state_nxt_s = S_RUN;
          end
        end
      end
      S_TMO: begin
        if (i_start) begin
          cnt_nxt_s   = 32'd0;
          k_nxt_s     = {ADDR_W{1'b0}};
          state_nxt_s = START_STATE;
        end else begin
          state_nxt_s = S_TMO;
        end
      end
      default: begin
        k_nxt_s     = {ADDR_W{1'b0}};
        cnt_nxt_s   = 32'd0;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    busy_nxt_s   = (state_nxt_s == S_CLEAR) || (state_nxt_s == S_READ) ||
                   (state_nxt_s == S_CAPT)  || (state_nxt_s == S_WRITE);
    run_nxt_s    = (state_nxt_s == S_RUN);
    tmo_nxt_s    = (state_nxt_s == S_TMO);
    src_rd_nxt_s = (state_nxt_s == S_READ);
    valid_nxt_s  = (state_nxt_s == S_CLEAR) || (state_nxt_s == S_WRITE);
    if (src_rd_nxt_s) begin
      src_addr_nxt_s = beat_addr(k_nxt_s);
    end else begin
      src_addr_nxt_s = {ADDR_W{1'b0}};
    end
    if (valid_nxt_s) begin
      tcm_addr_nxt_s = beat_addr(k_nxt_s);
    end else begin
      tcm_addr_nxt_s = {ADDR_W{1'b0}};
    end
    if (state_nxt_s == S_WRITE) begin
      wdata_nxt_s = data_nxt_s;
    end else begin
      wdata_nxt_s = {DATA_W{1'b0}};
    end
    if ((state_nxt_s == S_WRITE) && (k_nxt_s == LAST_K)) begin
      wstrb_nxt_s = LAST_STRB;
    end else if (valid_nxt_s) begin
      wstrb_nxt_s = FULL_STRB;
    end else begin
      wstrb_nxt_s = {BPB{1'b0}};
    end
  end

  // State and registered outputs; reset parks everything at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      k_r         <= {ADDR_W{1'b0}};
      data_r      <= {DATA_W{1'b0}};
      o_src_rd    <= 1'b0;
      o_src_addr  <= {ADDR_W{1'b0}};
      o_tcm_valid <= 1'b0;
      o_tcm_addr  <= {ADDR_W{1'b0}};
      o_tcm_wdata <= {DATA_W{1'b0}};
      o_tcm_wstrb <= {BPB{1'b0}};
      o_core_rstn <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_timeout   <= 1'b0;
      o_cycle_cnt <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      k_r         <= k_nxt_s;
      data_r      <= data_nxt_s;
      o_src_rd    <= src_rd_nxt_s;
      o_src_addr  <= src_addr_nxt_s;
      o_tcm_valid <= valid_nxt_s;
      o_tcm_addr  <= tcm_addr_nxt_s;
      o_tcm_wdata <= wdata_nxt_s;
      o_tcm_wstrb <= wstrb_nxt_s;
      o_core_rstn <= run_nxt_s;
      o_busy      <= busy_nxt_s;
      o_done      <= run_nxt_s;
      o_timeout   <= tmo_nxt_s;
      o_cycle_cnt <= cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_tcm_boot_loader.sv
// Bench for tcm_boot_loader: directed steps with random ROM contents and
// random TCM backpressure, checked against a beat-list model of the image.
module tb_tcm_boot_loader;

  localparam int AW   = 17;
  localparam int DW   = 32;
  localparam int BPB  = 4;
  localparam int LB_A = 10;
  localparam int LB_B = 9;
  localparam int MAXC = 20;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [3:0]    strb;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          a_start, a_src_rd, a_valid, a_ready, a_core_rstn, a_busy, a_done, a_timeout;
  logic [AW-1:0] a_src_addr, a_tcm_addr;
  logic [DW-1:0] a_src_rdata, a_wdata;
  logic [3:0]    a_wstrb;
  logic [31:0]   a_cnt;
  logic          b_start, b_src_rd, b_valid, b_ready, b_core_rstn, b_busy, b_done, b_timeout;
  logic [AW-1:0] b_src_addr, b_tcm_addr;
  logic [DW-1:0] b_src_rdata, b_wdata;
  logic [3:0]    b_wstrb;
  logic [31:0]   b_cnt;

  tcm_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .LOAD_BYTES(LB_A), .CLEAR_EN(1), .MAX_CYCLES(MAXC)) dut_a (
    .clk(clk), .rst(rst), .i_start(a_start), .o_src_rd(a_src_rd), .o_src_addr(a_src_addr),
    .i_src_rdata(a_src_rdata), .o_tcm_valid(a_valid), .i_tcm_ready(a_ready), .o_tcm_addr(a_tcm_addr),
    .o_tcm_wdata(a_wdata), .o_tcm_wstrb(a_wstrb), .o_core_rstn(a_core_rstn), .o_busy(a_busy),
    .o_done(a_done), .o_timeout(a_timeout), .o_cycle_cnt(a_cnt));

  tcm_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .LOAD_BYTES(LB_B), .CLEAR_EN(0), .MAX_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .i_start(b_start), .o_src_rd(b_src_rd), .o_src_addr(b_src_addr),
    .i_src_rdata(b_src_rdata), .o_tcm_valid(b_valid), .i_tcm_ready(b_ready), .o_tcm_addr(b_tcm_addr),
    .o_tcm_wdata(b_wdata), .o_tcm_wstrb(b_wstrb), .o_core_rstn(b_core_rstn), .o_busy(b_busy),
    .o_done(b_done), .o_timeout(b_timeout), .o_cycle_cnt(b_cnt));

  logic [31:0] rom [0:15];
  beat_t       obs_a[$];
  beat_t       obs_b[$];
  beat_t       exp_q[$];
  int unsigned cyc = 0;
  int unsigned hs_a_edge = 0;
  int unsigned hs_b_edge = 0;
  int          total = 0;
  int          bad = 0;
  bit          rdy_rand = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM answers one cycle after the read strobe; garbage otherwise.
  always @(posedge clk) begin
    a_src_rdata <= a_src_rd ? rom[a_src_addr[5:2]] : $urandom;
    b_src_rdata <= b_src_rd ? rom[b_src_addr[5:2]] : $urandom;
  end

  // Inputs only change just after a rising edge, so a handshake seen here
  // completes on the next rising edge.
  always @(negedge clk) begin
    if (!rst && a_valid && a_ready) begin
      obs_a.push_back(beat_t'({a_tcm_addr, a_wdata, a_wstrb}));
      hs_a_edge = cyc + 1;
    end
    if (!rst && b_valid && b_ready) begin
      obs_b.push_back(beat_t'({b_tcm_addr, b_wdata, b_wstrb}));
      hs_b_edge = cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [127:0] o, input logic [127:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    if (rdy_rand) begin
      a_ready = 1'($urandom_range(0, 1));
      b_ready = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic logic [127:0] a_outs();
    return 128'({a_src_rd, a_src_addr, a_valid, a_tcm_addr, a_wdata, a_wstrb,
                 a_core_rstn, a_busy, a_done, a_timeout, a_cnt});
  endfunction

  function automatic logic [127:0] b_outs();
    return 128'({b_src_rd, b_src_addr, b_valid, b_tcm_addr, b_wdata, b_wstrb,
                 b_core_rstn, b_busy, b_done, b_timeout, b_cnt});
  endfunction

  // Expected TCM write list: optional zero beats, then the image beat by beat.
  function automatic void build_exp(input int lb, input bit clr);
    int    nb;
    int    rem;
    beat_t b;
    nb  = (lb + BPB - 1) / BPB;
    rem = lb % BPB;
    exp_q.delete();
    if (clr) begin
      for (int k = 0; k < nb; k++) begin
        b.addr = AW'(k * BPB);
        b.data = 32'h0;
        b.strb = 4'hF;
        exp_q.push_back(b);
      end
    end
    for (int k = 0; k < nb; k++) begin
      b.addr = AW'(k * BPB);
      b.data = rom[k];
      b.strb = ((k == nb - 1) && (rem != 0)) ? 4'((1 << rem) - 1) : 4'hF;
      exp_q.push_back(b);
    end
  endfunction

  task automatic check_seq(input bit use_b, input int base, input string tag);
    int    got;
    beat_t b;
    got = use_b ? (obs_b.size() - base) : (obs_a.size() - base);
    check({tag, "_count"}, 128'(got), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got; i++) begin
      b = use_b ? obs_b[base + i] : obs_a[base + i];
      check($sformatf("%s_beat%0d", tag, i), 128'(b), 128'(exp_q[i]));
    end
  endtask

  task automatic wait_done(input bit use_b, input int bound, output int unsigned edge_n);
    int n;
    n = 0;
    while (!(use_b ? b_done : a_done) && n < bound) begin
      tick();
      n++;
    end
    edge_n = cyc;
    check(use_b ? "b_done_in_time" : "a_done_in_time", 128'(use_b ? b_done : a_done), 128'(1));
  endtask

  task automatic wait_obs_a(input int base, input int cnt);
    int n;
    n = 0;
    while ((obs_a.size() - base) < cnt && n < 100) begin
      tick();
      n++;
    end
    check("a_obs_in_time", 128'(obs_a.size() - base), 128'(cnt));
  endtask

  task automatic pulse_a_start();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  initial begin
    int unsigned s, r, t, badcyc;
    int          base, n;
    a_start = 1'b0; b_start = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = 32'h0;

    // Reset state, then idle with ready high must do nothing.
    repeat (3) tick();
    check("a_reset_outs", a_outs(), 128'h0);
    check("b_reset_outs", b_outs(), 128'h0);
    rst = 1'b0;
    a_ready = 1'b1;
    repeat (3) tick();
    check("a_idle_ignores_ready", a_outs(), 128'h0);

    // Zero-fill then copy of fixed words with ready held high.
    rom[0] = 32'h11223344; rom[1] = 32'h55667788; rom[2] = 32'h99AABBCC;
    base = obs_a.size();
    pulse_a_start();
    s = cyc;
    check("a_first_clear_beat", 128'({a_valid, a_tcm_addr, a_wdata, a_wstrb, a_busy, a_core_rstn}),
          128'({1'b1, 17'd0, 32'd0, 4'hF, 1'b1, 1'b0}));
    wait_done(1'b0, 200, r);
    check("a_load_cycles", 128'(r - s), 128'(3 + 3 * 3));
    check("a_rstn_after_last_hs", 128'(r), 128'(hs_a_edge));
    check("a_run_outs", 128'({a_core_rstn, a_done, a_busy, a_timeout, a_valid, a_cnt}),
          128'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0}));
    build_exp(LB_A, 1'b1);
    check_seq(1'b0, base, "a_fixed");

    // Watchdog: counter runs, then expires after MAXC run cycles and freezes.
    repeat (7) tick();
    check("a_cnt_mid_run", 128'(a_cnt), 128'(7));
    n = 0;
    while (!a_timeout && n < 100) begin
      tick();
      n++;
    end
    t = cyc;
    check("a_run_length", 128'(t - r), 128'(MAXC));
    check("a_tmo_outs", 128'({a_timeout, a_done, a_core_rstn, a_cnt}),
          128'({1'b1, 1'b0, 1'b0, 32'(MAXC)}));
    repeat (5) tick();
    check("a_tmo_frozen", 128'({a_timeout, a_cnt}), 128'({1'b1, 32'(MAXC)}));

    // Restart from timeout, with backpressure on copy beat 1.
    pulse_a_start();
    check("a_restart_outs", 128'({a_timeout, a_done, a_core_rstn, a_busy, a_cnt}),
          128'({1'b0, 1'b0, 1'b0, 1'b1, 32'd0}));
    base = obs_a.size();
    wait_obs_a(base, 4);
    a_ready = 1'b0;
    n = 0;
    while (!a_valid && n < 10) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      check($sformatf("a_bp_hold%0d", i), 128'({a_valid, a_tcm_addr, a_wdata, a_wstrb}),
            128'({1'b1, 17'd4, rom[1], 4'hF}));
      tick();
    end
    check("a_bp_no_write", 128'(obs_a.size() - base), 128'(4));
    a_ready = 1'b1;
    wait_done(1'b0, 200, r);
    build_exp(LB_A, 1'b1);
    check_seq(1'b0, base, "a_bp");

    // Random images under random backpressure; start pulses while busy are ignored.
    rdy_rand = 1'b1;
    for (int run = 0; run < 3; run++) begin
      for (int i = 0; i < 3; i++) rom[i] = $urandom;
      base = obs_a.size();
      pulse_a_start();
      n = 0;
      while (!a_done && n < 500) begin
        a_start = a_busy ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        n++;
      end
      a_start = 1'b0;
      check($sformatf("a_rand%0d_done", run), 128'(a_done), 128'(1));
      build_exp(LB_A, 1'b1);
      check_seq(1'b0, base, $sformatf("a_rand%0d", run));
    end

    // Reset in the middle of the beat-1 write: nothing written, all outputs zero.
    rdy_rand = 1'b0;
    a_ready = 1'b1;
    pulse_a_start();
    base = obs_a.size();
    wait_obs_a(base, 4);
    a_ready = 1'b0;
    n = 0;
    while (!a_valid && n < 10) begin
      tick();
      n++;
    end
    check("a_pre_rst_valid", 128'(a_valid), 128'(1));
    rst = 1'b1;
    tick();
    check("a_rst_midcopy_outs", a_outs(), 128'h0);
    check("a_rst_no_handshake", 128'(obs_a.size() - base), 128'(4));
    rst = 1'b0;
    a_ready = 1'b1;
    repeat (3) tick();
    check("a_after_rst_idle", a_outs(), 128'h0);
    for (int i = 0; i < 3; i++) rom[i] = $urandom;
    base = obs_a.size();
    pulse_a_start();
    wait_done(1'b0, 200, r);
    build_exp(LB_A, 1'b1);
    check_seq(1'b0, base, "a_reload");

    // No zero-fill, watchdog disabled: core keeps running.
    rdy_rand = 1'b1;
    for (int i = 0; i < 3; i++) rom[i] = $urandom;
    base = obs_b.size();
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("b_first_is_read", 128'({b_src_rd, b_src_addr, b_valid, b_busy}),
          128'({1'b1, 17'd0, 1'b0, 1'b1}));
    wait_done(1'b1, 500, r);
    check("b_rstn_after_last_hs", 128'(r), 128'(hs_b_edge));
    build_exp(LB_B, 1'b0);
    check_seq(1'b1, base, "b_copy");
    badcyc = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (b_timeout || !b_core_rstn) badcyc++;
    end
    check("b_no_timeout_cycles", 128'(badcyc), 128'(0));
    check("b_run_cnt", 128'({b_done, b_cnt}), 128'({1'b1, 32'd1000}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
